// File: rtl/dmux4_dispatch_ctrl_pkg.sv
// Shared definitions for the 4-way dispatch controller: FSM encoding,
// destination codes and the select-to-strobe decode.
package dmux4_dispatch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_BCAST = 2'd2
    } state_e;

    localparam logic [1:0] DEST_A = 2'd0;
    localparam logic [1:0] DEST_B = 2'd1;
    localparam logic [1:0] DEST_C = 2'd2;
    localparam logic [1:0] DEST_D = 2'd3;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/dmux4_dispatch_ctrl_dispatch_fifo.sv
// Small power-of-two FIFO holding tagged words; head is visible
// combinationally so the controller can load it on the same edge it leaves IDLE.
module dispatch_fifo #(
    parameter  int W     = 19,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/dmux4_dispatch_ctrl.sv
// Dispatch controller: pulls tagged words from the FIFO and presents them to
// one destination (tagged or round-robin) or to all four in turn.
module dmux4_dispatch_ctrl
    import dmux4_dispatch_ctrl_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_dest,
    input  logic             in_bcast,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode_rr,
    output logic [1:0]       out_sel,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic             busy,
    output logic [CW-1:0]    fifo_count
);

    localparam int EW = WIDTH + 3;

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       bidx_q, bidx_d;
    logic [1:0]       rr_q, rr_d;
    logic             used_rr_q, used_rr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [EW-1:0]    head;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;

    assign in_ready = !fifo_full;

    dispatch_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_valid && in_ready),
        .pop_i   (pop),
        .wdata_i ({in_data, in_dest, in_bcast}),
        .rdata_o (head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= DEST_A;
            bidx_q    <= 2'd0;
            rr_q      <= 2'd0;
            used_rr_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            bidx_q    <= bidx_d;
            rr_q      <= rr_d;
            used_rr_q <= used_rr_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        bidx_d    = bidx_q;
        rr_d      = rr_q;
        used_rr_d = used_rr_q;
        data_d    = data_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    data_d = head[EW-1:3];
                    if (head[0]) begin
                        state_d   = ST_BCAST;
                        bidx_d    = 2'd0;
                        sel_d     = DEST_A;
                        used_rr_d = 1'b0;
                    end else begin
                        state_d   = ST_SEND;
                        used_rr_d = mode_rr;
                        sel_d     = mode_rr ? rr_q : head[2:1];
                    end
                end
            end
            ST_SEND: begin
                if (out_ready[sel_q]) begin
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                    if (used_rr_q) rr_d = rr_q + 2'd1;
                end
            end
            ST_BCAST: begin
                if (out_ready[bidx_q]) begin
                    if (bidx_q == 2'd3) begin
                        pop     = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        bidx_d = bidx_q + 2'd1;
                        sel_d  = bidx_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = 4'b0000;
        case (state_q)
            ST_SEND:  out_valid = onehot4(sel_q);
            ST_BCAST: out_valid = onehot4(bidx_q);
            default:  out_valid = 4'b0000;
        endcase
        out_sel  = sel_q;
        out_data = data_q;
        busy     = (state_q != ST_IDLE) || (fifo_count != '0);
    end

endmodule

// File: tb/tb_dmux4_dispatch_ctrl.sv
// Directed plus randomized bench; expected deliveries are derived from the
// routing rules into a queue of (destination, data) events.
module tb_dmux4_dispatch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] in_data = '0;
    logic [1:0]  in_dest = '0;
    logic        in_bcast = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mode_rr = 1'b0;
    logic [1:0]  out_sel;
    logic [15:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = 4'b1111;
    logic        busy;
    logic [1:0]  fifo_count;

    dmux4_dispatch_ctrl #(.WIDTH(16), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .in_bcast   (in_bcast),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode_rr    (mode_rr),
        .out_sel    (out_sel),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  dest;
        logic [15:0] data;
        bit          last;
    } dlv_t;

    dlv_t q[$];
    int   m_cnt = 0;
    int   m_rr = 0;
    bit   m_present = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // A word expands into one delivery, or four for a broadcast.
    task automatic model_push(input logic [15:0] d, input logic [1:0] dst, input bit bc);
        dlv_t e;
        e.data = d;
        if (bc) begin
            for (int k = 0; k < 4; k++) begin
                e.dest = 2'(k);
                e.last = (k == 3);
                q.push_back(e);
            end
        end else begin
            e.dest = mode_rr ? 2'(m_rr) : dst;
            e.last = 1;
            if (mode_rr) m_rr = (m_rr + 1) % 4;
            q.push_back(e);
        end
    endtask

    task automatic step();
        bit   push;
        bit   popw;
        dlv_t f;
        @(negedge clk);
        chk("fifo_count", 32'(fifo_count), m_cnt);
        chk("in_ready", 32'(in_ready), 32'(m_cnt < 2));
        chk("busy", 32'(busy), 32'(m_cnt != 0));
        popw = 0;
        if (m_present) begin
            f = q[0];
            chk("out_valid", 32'(out_valid), 32'(4'b0001 << f.dest));
            chk("out_sel", 32'(out_sel), 32'(f.dest));
            chk("out_data", 32'(out_data), 32'(f.data));
            if (out_ready[f.dest]) begin
                void'(q.pop_front());
                if (f.last) begin
                    popw = 1;
                    m_present = 0;
                end
            end
        end else begin
            chk("out_valid_idle", 32'(out_valid), 0);
            m_present = (m_cnt != 0);
        end
        push = in_valid && (m_cnt < 2);
        if (push) model_push(in_data, in_dest, in_bcast);
        m_cnt = m_cnt + int'(push) - int'(popw);
        $display("t=%0t push=%0b pop=%0b valid=%b sel=%0d data=%h cnt=%0d",
                 $time, push, popw, out_valid, out_sel, out_data, fifo_count);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] dst, input bit bc);
        bit ok;
        bit done;
        done = 0;
        in_data = d; in_dest = dst; in_bcast = bc; in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            ok = (m_cnt < 2);
            step();
            if (ok) begin
                done = 1;
                break;
            end
        end
        in_valid = 1'b0;
        chk("send_accepted", 32'(done), 1);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0 && m_cnt == 0 && !m_present) begin
                ok = 1;
                break;
            end
            step();
        end
        chk("drain_done", 32'(ok), 1);
        step();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_fifo_count", 32'(fifo_count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_sel", 32'(out_sel), 0);
        chk("rst_out_data", 32'(out_data), 0);
        q.delete();
        m_cnt = 0; m_rr = 0; m_present = 0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit hit;
        do_reset();

        // Tagged delivery.
        mode_rr = 1'b0; out_ready = 4'b1111;
        send(16'h1234, 2'd2, 1'b0);
        drain();

        // Round-robin, back-to-back pushes.
        mode_rr = 1'b1;
        for (int i = 0; i < 5; i++) send(16'hAAA0 + 16'(i), 2'd0, 1'b0);
        drain();

        // Broadcast, then confirm the round-robin pointer was untouched.
        send(16'hBEEF, 2'd0, 1'b1);
        send(16'h1111, 2'd3, 1'b0);
        drain();

        // Selected consumer stalls; others ready bits are ignored.
        mode_rr = 1'b0; out_ready = 4'b1101;
        send(16'h2222, 2'd1, 1'b0);
        repeat (5) step();
        out_ready = 4'b1111;
        drain();

        // Fill with consumer stalled, then release.
        out_ready = 4'b0000;
        send(16'h3001, 2'd3, 1'b0);
        send(16'h3002, 2'd0, 1'b0);
        repeat (4) step();
        out_ready = 4'b1111;
        drain();

        // Reset in the middle of a broadcast.
        send(16'h4444, 2'd0, 1'b1);
        hit = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_present && q.size() == 2 && q[0].dest == 2'd2) begin
                hit = 1;
                break;
            end
            step();
        end
        chk("reached_bidx2", 32'(hit), 1);
        do_reset();
        mode_rr = 1'b1;
        send(16'h5555, 2'd3, 1'b0);
        drain();

        // Randomized traffic; routing mode changes only while fully idle.
        for (int i = 0; i < 400; i++) begin
            if (q.size() == 0 && m_cnt == 0 && !m_present && $urandom_range(0, 3) == 0)
                mode_rr = 1'($urandom);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            in_dest   = 2'($urandom);
            in_bcast  = ($urandom_range(0, 5) == 0);
            out_ready = 4'($urandom);
            step();
        end
        in_valid = 1'b0;
        out_ready = 4'b1111;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
